// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, instruction
// field positions and the fetch FSM state encoding.
package fetch_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b100011;
  localparam logic [5:0] OP_BNE   = 6'b100111;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JAL   = 6'b111001;

  localparam int OPC_MSB    = 31;
  localparam int OPC_LSB    = 26;
  localparam int TGT_MSB    = 25;
  localparam int IMM_MSB    = 15;
  // Set for bne, clear for beq: selects which zero-flag polarity means taken.
  localparam int BR_POL_BIT = 28;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] sext_imm(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection: jump over taken branch over sequential.
module next_pc_logic
  import fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic        alu_zero_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o
);

  logic [31:0] branch_off;
  logic        taken;

  always_comb begin
    pc_plus4_o = pc_i + 32'd4;
    branch_off = sext_imm(instr_i[IMM_MSB:0]) << 2;
    taken      = instr_i[BR_POL_BIT] ? ~alu_zero_i : alu_zero_i;
    next_pc_o  = pc_plus4_o;
    if (jump_i) begin
      next_pc_o = {pc_plus4_o[31:28], instr_i[TGT_MSB:0], 2'b00};
    end else if (branch_i && taken) begin
      next_pc_o = pc_plus4_o + branch_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory port and
// holds the word in an instruction register until the datapath retires it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        jump,
  input  logic        alu_zero,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: imem_req stays high in FETCH until a cycle with imem_ack=1
  // (data captured that edge); instr_valid stays high in VALID until a cycle
  // with instr_ready=1. Either input is ignored when its partner is low.

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   next_pc;

  next_pc_logic u_next_pc (
    .pc_i       (pc_q),
    .instr_i    (instr_q),
    .branch_i   (branch),
    .jump_i     (jump),
    .alu_zero_i (alu_zero),
    .pc_plus4_o (pc_plus4),
    .next_pc_o  (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = ST_VALID;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_VALID: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
      ST_ERR: state_d = ST_ERR;
      default: state_d = ST_RST;
    endcase
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPC_MSB:OPC_LSB];
  assign instr_valid = (state_q == ST_VALID);
  assign pc          = pc_q;
  assign fetch_err   = (state_q == ST_ERR);
  assign dbg_state   = state_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of control_unit. It owns the PC, fetches 32-bit instructions over a request/acknowledge instruction-memory port, and holds each one in an instruction register. IR[31:26] drives control_unit.opcode. On retirement it selects the next PC from sequential, branch (beq/bne) or jump (j/jal) using the control_unit branch/jump outputs and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, max cycles imem_req may stay high without imem_ack before fault (>=1).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, held until acked
imem_addr  out  32  fetch address (= pc while imem_req)
imem_ack  in  1  memory returns imem_rdata this cycle; ignored when imem_req=0
imem_rdata  in  32  instruction word
instr  out  32  instruction register
opcode  out  6  instr[31:26], to control_unit
instr_valid  out  1  instr is valid and awaiting retirement
instr_ready  in  1  datapath retires instr this cycle
pc  out  32  address of instr
pc_plus4  out  32  pc+4 (jal link value)
branch  in  1  from control_unit
jump  in  1  from control_unit
alu_zero  in  1  ALU zero flag for current instr
fetch_err  out  1  sticky timeout fault

Behaviour:
- Reset (rst_n low, async): state=RST, pc=RESET_PC, instr=0, timeout count=0. Outputs imem_req=0, instr_valid=0, fetch_err=0 immediately, mid-transaction included. Late acks after reset are ignored.
- States:
  - RST: one cycle after rst_n release, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc, count increments each cycle.
    - imem_ack: instr<=imem_rdata, count<=0, go VALID. Zero-wait ack in the first FETCH cycle is legal.
    - No ack and count reaches TIMEOUT-1: go ERR.
  - VALID: instr_valid=1, imem_req=0.
    - instr_ready=1: pc<=next_pc, go FETCH.
    - instr_ready=0: hold instr and pc unchanged.
  - ERR: fetch_err=1, imem_req=0, instr_valid=0. Leaves only on reset.
- next_pc is evaluated only in VALID with instr_ready=1. Priority order:
  1. jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  2. branch=1 and taken: pc_plus4 + (sext(instr[15:0])<<2). Taken means instr[28]=0 (beq, opcode 100011) and alu_zero=1, or instr[28]=1 (bne, opcode 100111) and alu_zero=0.
  3. Otherwise pc_plus4.
- Arithmetic is 32-bit modulo 2^32. 0xFFFF_FFFC+4 wraps to 0; negative offsets wrap likewise.
- branch and jump both high: jump wins.
- instr_ready outside VALID is ignored.
- Latency: retire to next imem_req is 1 cycle. Ack to instr_valid is 1 cycle. Minimum 2 cycles per instruction.
- PC alignment is not checked. pc[1:0] stays 0 when RESET_PC is aligned.

Decomposition:
- Package fetch_pkg holds:
  - opcode constants: OP_RTYPE 000000, OP_BEQ 100011, OP_BNE 100111, OP_J 111000, OP_JAL 111001.
  - instruction field bit positions (opcode 31:26, target 25:0, imm 15:0, branch-polarity bit 28).
  - state encoding: RST, FETCH, VALID, ERR.
- Sub-module next_pc_logic: purely combinational. Inputs pc, instr, branch, jump, alu_zero; outputs pc_plus4, next_pc. Reused by the verification model.

Test Plan:
- RESET_PC=32'h0040_0000; release rst_n -> one RST cycle, then imem_req=1, imem_addr=0x0040_0000, instr_valid=0.
- Three R-type words (0x0000_0020), ack latency 2, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; instr_valid pulses once per word; opcode=000000.
- pc=0x10, instr=0x8C00_0003 (beq), branch=1, alu_zero=1 -> next imem_addr 0x20. Same with imm 0xFFFE -> 0x0C. bne 0x9C00_0003 with alu_zero=1 -> 0x14.
- pc=0x1000_0040, instr=0xE400_0100 (jal), jump=1, branch=1 -> pc_plus4=0x1000_0044, next imem_addr=0x1000_0400.
- instr_ready held 0 for 5 cycles in VALID -> instr, pc, instr_valid stable, imem_req=0; retire on cycle 6 -> fetch resumes next cycle.
- No ack for 16 cycles -> fetch_err=1, imem_req=0 from cycle 17, persists. Then rst_n pulse mid-FETCH -> imem_req=0 combinationally, restart at RESET_PC.
